cpu_session_ctrl: RTL and testbench

- Sequencer that drives one complete CPU session through the CPU's external memory ports and its enable and reset inputs.
- A session has four phases, in order:
  - load instruction memory from an input stream;
  - load data memory from the same stream;
  - run the CPU for a programmed number of cycles;
  - read back a data-memory region onto an output stream.
- Sits between the testbench/host and the cpu top level, and replaces hand-driven addr_ext/wen_ext sequencing.

---
 rtl/cpu_session_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_cpu_session_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_session_ctrl.sv
// Session sequencer for the CPU top level: streams instruction and data memory
// images in, runs the core for a fixed number of cycles, then streams a data region out.
module cpu_session_ctrl #(
    parameter int IMEM_WORDS = 128,
    parameter int DMEM_WORDS = 256,
    parameter int CYCLE_W    = 32
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               start,
    input  logic [15:0]        imem_len,
    input  logic [15:0]        dmem_len,
    input  logic [CYCLE_W-1:0] run_cycles,
    input  logic [15:0]        dump_len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [63:0]        in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [63:0]        out_data,
    output logic               cpu_rst_n,
    output logic               cpu_enable,
    output logic [63:0]        addr_ext,
    output logic               wen_ext,
    output logic               ren_ext,
    output logic [31:0]        wdata_ext,
    output logic [63:0]        addr_ext_2,
    output logic               wen_ext_2,
    output logic               ren_ext_2,
    output logic [63:0]        wdata_ext_2,
    input  logic [63:0]        rdata_ext_2,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_I,
        LOAD_D,
        RUN,
        DUMP_RD,
        DUMP_CAP,
        DUMP_OUT,
        DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [15:0]        cnt_reg, cnt_next;
    logic [15:0]        imem_len_reg, imem_len_next;
    logic [15:0]        dmem_len_reg, dmem_len_next;
    logic [15:0]        dump_len_reg, dump_len_next;
    logic [CYCLE_W-1:0] run_cnt_reg, run_cnt_next;
    logic [63:0]        out_data_reg, out_data_next;
    logic               cpu_rst_n_reg;
    logic               cpu_enable_reg;

    logic [15:0] imem_clamped, dmem_clamped, dump_clamped;

    assign imem_clamped = (imem_len > 16'(IMEM_WORDS)) ? 16'(IMEM_WORDS) : imem_len;
    assign dmem_clamped = (dmem_len > 16'(DMEM_WORDS)) ? 16'(DMEM_WORDS) : dmem_len;
    assign dump_clamped = (dump_len > 16'(DMEM_WORDS)) ? 16'(DMEM_WORDS) : dump_len;

    // First phase, in session order, whose length is nonzero; DONE if none remain.
    function automatic state_t pick_phase(input logic i_nz, input logic d_nz,
                                          input logic r_nz, input logic u_nz);
        if (i_nz)      return LOAD_I;
        else if (d_nz) return LOAD_D;
        else if (r_nz) return RUN;
        else if (u_nz) return DUMP_RD;
        else           return DONE;
    endfunction

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        imem_len_next = imem_len_reg;
        dmem_len_next = dmem_len_reg;
        dump_len_next = dump_len_reg;
        run_cnt_next  = run_cnt_reg;
        out_data_next = out_data_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    imem_len_next = imem_clamped;
                    dmem_len_next = dmem_clamped;
                    dump_len_next = dump_clamped;
                    run_cnt_next  = run_cycles;
                    cnt_next      = '0;
                    state_next    = pick_phase(imem_clamped != '0, dmem_clamped != '0,
                                               run_cycles != '0, dump_clamped != '0);
                end
            end
            LOAD_I: begin
                if (in_valid) begin
                    if (cnt_reg == imem_len_reg - 16'd1) begin
                        cnt_next   = '0;
                        state_next = pick_phase(1'b0, dmem_len_reg != '0,
                                                run_cnt_reg != '0, dump_len_reg != '0);
                    end else begin
                        cnt_next = cnt_reg + 16'd1;
                    end
                end
            end
            LOAD_D: begin
                if (in_valid) begin
                    if (cnt_reg == dmem_len_reg - 16'd1) begin
                        cnt_next   = '0;
                        state_next = pick_phase(1'b0, 1'b0,
                                                run_cnt_reg != '0, dump_len_reg != '0);
                    end else begin
                        cnt_next = cnt_reg + 16'd1;
                    end
                end
            end
            RUN: begin
                // Leaving as the counter hits its last unit makes RUN last exactly run_cycles cycles.
                run_cnt_next = run_cnt_reg - CYCLE_W'(1);
                if (run_cnt_reg <= CYCLE_W'(1)) begin
                    state_next = pick_phase(1'b0, 1'b0, 1'b0, dump_len_reg != '0);
                end
            end
            DUMP_RD: begin
                state_next = DUMP_CAP;
            end
            DUMP_CAP: begin
                out_data_next = rdata_ext_2;
                state_next    = DUMP_OUT;
            end
            DUMP_OUT: begin
                if (out_ready) begin
                    if (cnt_reg == dump_len_reg - 16'd1) begin
                        cnt_next   = '0;
                        state_next = DONE;
                    end else begin
                        cnt_next   = cnt_reg + 16'd1;
                        state_next = DUMP_RD;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            imem_len_reg   <= '0;
            dmem_len_reg   <= '0;
            dump_len_reg   <= '0;
            run_cnt_reg    <= '0;
            out_data_reg   <= '0;
            cpu_rst_n_reg  <= 1'b0;
            cpu_enable_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            imem_len_reg   <= imem_len_next;
            dmem_len_reg   <= dmem_len_next;
            dump_len_reg   <= dump_len_next;
            run_cnt_reg    <= run_cnt_next;
            out_data_reg   <= out_data_next;
            // Core is held in reset while its memories are being written, so it starts at PC 0.
            cpu_rst_n_reg  <= !(state_next inside {IDLE, LOAD_I, LOAD_D});
            cpu_enable_reg <= (state_next == RUN);
        end
    end

    assign in_ready    = (state_reg == LOAD_I) || (state_reg == LOAD_D);
    assign wen_ext     = (state_reg == LOAD_I) && in_valid;
    assign ren_ext     = 1'b0;
    assign addr_ext    = (state_reg == LOAD_I) ? {46'd0, cnt_reg, 2'b00} : '0;
    assign wdata_ext   = (state_reg == LOAD_I) ? in_data[31:0] : '0;

    assign wen_ext_2   = (state_reg == LOAD_D) && in_valid;
    assign ren_ext_2   = (state_reg == DUMP_RD);
    assign addr_ext_2  = ((state_reg == LOAD_D) || (state_reg == DUMP_RD)) ?
                         {45'd0, cnt_reg, 3'b000} : '0;
    assign wdata_ext_2 = (state_reg == LOAD_D) ? in_data : '0;

    assign out_valid   = (state_reg == DUMP_OUT);
    assign out_data    = out_data_reg;
    assign cpu_rst_n   = cpu_rst_n_reg;
    assign cpu_enable  = cpu_enable_reg;
    assign busy        = (state_reg != IDLE) && (state_reg != DONE);
    assign done        = (state_reg == DONE);

endmodule

// File: tb/tb_cpu_session_ctrl.sv
// Scoreboard bench for cpu_session_ctrl: sessions are described by lengths and a word stream,
// expected memory writes and dumped words are queued up front and matched by a monitor.
module tb_cpu_session_ctrl;
    localparam int IMEM_WORDS = 128;
    localparam int DMEM_WORDS = 256;
    localparam int CYCLE_W    = 32;
    localparam int LIMIT      = 8000;
    localparam logic [63:0] MEM_INIT = 64'hA5A5_5A5A_0F0F_F0F0;

    logic               clk = 1'b0;
    logic               arst_n;
    logic               start;
    logic [15:0]        imem_len, dmem_len, dump_len;
    logic [CYCLE_W-1:0] run_cycles;
    logic               in_valid, in_ready;
    logic [63:0]        in_data;
    logic               out_valid, out_ready;
    logic [63:0]        out_data;
    logic               cpu_rst_n, cpu_enable;
    logic [63:0]        addr_ext, addr_ext_2;
    logic               wen_ext, ren_ext, wen_ext_2, ren_ext_2;
    logic [31:0]        wdata_ext;
    logic [63:0]        wdata_ext_2;
    logic [63:0]        rdata_ext_2 = '0;
    logic               busy, done;

    cpu_session_ctrl #(.IMEM_WORDS(IMEM_WORDS), .DMEM_WORDS(DMEM_WORDS), .CYCLE_W(CYCLE_W)) dut (
        .clk(clk), .arst_n(arst_n), .start(start),
        .imem_len(imem_len), .dmem_len(dmem_len), .run_cycles(run_cycles), .dump_len(dump_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cpu_rst_n(cpu_rst_n), .cpu_enable(cpu_enable),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;
    int          in_mode  = 0;
    int          or_mode  = 0;
    int          en_cnt   = 0;
    int          en_rises = 0;
    int          out_idx  = 0;
    bit          ren_seen = 1'b0;

    logic [63:0]  in_q[$];
    logic [63:0]  fixed_q[$];
    logic [127:0] exp_i[$];
    logic [127:0] exp_d[$];
    logic [63:0]  exp_o[$];

    // External data memory the controller drives, and the bench's own view of its contents.
    logic [63:0] dmem_model [0:DMEM_WORDS-1] = '{default: MEM_INIT};
    logic [63:0] ref_dmem   [0:DMEM_WORDS-1] = '{default: MEM_INIT};

    always @(posedge clk) begin
        if (wen_ext_2) dmem_model[addr_ext_2[10:3]] <= wdata_ext_2;
        if (ren_ext_2) rdata_ext_2 <= dmem_model[addr_ext_2[10:3]];
    end

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [63:0] next_word();
        if (fixed_q.size() > 0) return fixed_q.pop_front();
        return {$urandom, $urandom};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Input stream source with selectable gap pattern.
    initial begin
        bit acc;
        in_valid = 1'b0;
        in_data  = '0;
        forever begin
            @(negedge clk);
            acc = in_valid && in_ready && arst_n;
            @(posedge clk);
            #1;
            if (acc && in_q.size() > 0) void'(in_q.pop_front());
            if (in_q.size() > 0 && (in_mode == 0 || (in_mode == 1 && cyc % 3 == 0) ||
                                    (in_mode == 2 && $urandom_range(0, 1) == 1))) begin
                in_valid = 1'b1;
                in_data  = in_q[0];
            end else begin
                in_valid = 1'b0;
                in_data  = {$urandom, $urandom};
            end
        end
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 1) == 1);
                default: out_ready = (cyc % 5 == 4);
            endcase
        end
    end

    // Monitor: matches every observed write / dumped word against the queued expectations.
    initial begin
        logic [127:0] e;
        logic [63:0]  held;
        bit           stall_prev;
        bit           en_prev;
        stall_prev = 1'b0;
        en_prev    = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            if (arst_n) begin
                if (wen_ext) begin
                    chk("imem_wr_expected", exp_i.size() != 0, 1'b1);
                    chk("cpu_rst_n_during_load_i", cpu_rst_n, 1'b0);
                    if (exp_i.size() != 0) begin
                        e = exp_i.pop_front();
                        chk("imem_wr_addr_data", {addr_ext, 32'h0, wdata_ext}, e);
                    end
                end
                if (wen_ext_2) begin
                    chk("dmem_wr_expected", exp_d.size() != 0, 1'b1);
                    chk("cpu_rst_n_during_load_d", cpu_rst_n, 1'b0);
                    if (exp_d.size() != 0) begin
                        e = exp_d.pop_front();
                        chk("dmem_wr_addr_data", {addr_ext_2, wdata_ext_2}, e);
                    end
                end
                if (out_valid) begin
                    if (stall_prev) chk("out_data_hold", out_data, held);
                    if (out_ready) begin
                        chk("out_expected", exp_o.size() != 0, 1'b1);
                        if (exp_o.size() != 0) begin
                            e = {64'h0, exp_o.pop_front()};
                            chk("out_data", out_data, e);
                        end
                        $display("out word %0d data=%h", out_idx, out_data);
                        out_idx++;
                    end
                    stall_prev = !out_ready;
                    held       = out_data;
                end else begin
                    stall_prev = 1'b0;
                end
                if (cpu_enable) begin
                    chk("cpu_rst_n_while_enabled", cpu_rst_n, 1'b1);
                    en_cnt++;
                    if (!en_prev) en_rises++;
                end
                en_prev = cpu_enable;
                if (ren_ext) ren_seen = 1'b1;
            end else begin
                stall_prev = 1'b0;
                en_prev    = 1'b0;
            end
        end
    end

    task automatic check_quiet(input string tag);
        chk({tag, "_ctrl"}, {cpu_rst_n, cpu_enable, out_valid, in_ready, busy, done,
                             wen_ext, wen_ext_2, ren_ext, ren_ext_2}, '0);
        chk({tag, "_addr"}, {addr_ext, addr_ext_2}, '0);
        chk({tag, "_wdata"}, {wdata_ext, wdata_ext_2}, '0);
        chk({tag, "_out_data"}, out_data, '0);
    endtask

    // One session: queue stimulus and expectations from the lengths, start it, then either
    // wait for DONE and audit it, or cut it short with arst_n in the second RUN cycle.
    task automatic run_session(input int ilen, input int dlen, input int rc, input int ulen,
                               input bit poke, input bit abort, output int lat);
        int ni, nd, nu, eb, rb, t;
        bit met;
        logic [63:0] w;
        ni = (ilen > IMEM_WORDS) ? IMEM_WORDS : ilen;
        nd = (dlen > DMEM_WORDS) ? DMEM_WORDS : dlen;
        nu = (ulen > DMEM_WORDS) ? DMEM_WORDS : ulen;
        $display("session ilen=%0d dlen=%0d run=%0d dump=%0d in_mode=%0d or_mode=%0d poke=%0d abort=%0d",
                 ilen, dlen, rc, ulen, in_mode, or_mode, poke, abort);
        for (int i = 0; i < ni; i++) begin
            w = next_word();
            in_q.push_back(w);
            exp_i.push_back({64'(4 * i), 32'h0, w[31:0]});
        end
        for (int j = 0; j < nd; j++) begin
            w = next_word();
            in_q.push_back(w);
            ref_dmem[j] = w;
            exp_d.push_back({64'(8 * j), w});
        end
        if (!abort) begin
            for (int k = 0; k < nu; k++) exp_o.push_back(ref_dmem[k]);
        end
        @(posedge clk);
        #1;
        imem_len   = 16'(ilen);
        dmem_len   = 16'(dlen);
        run_cycles = CYCLE_W'(rc);
        dump_len   = 16'(ulen);
        start      = 1'b1;
        eb = en_cnt;
        rb = en_rises;
        @(posedge clk);
        #1;
        start      = 1'b0;
        imem_len   = 16'($urandom);
        dmem_len   = 16'($urandom);
        run_cycles = CYCLE_W'($urandom);
        dump_len   = 16'($urandom);
        if (poke) begin
            met = 1'b0;
            for (t = 0; t < LIMIT && !met; t++) begin
                @(negedge clk);
                #1;
                met = cpu_enable;
            end
            chk("poke_wait_run", met, 1'b1);
            @(posedge clk);
            #1;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        if (abort) begin
            met = 1'b0;
            for (t = 0; t < LIMIT && !met; t++) begin
                @(negedge clk);
                #1;
                met = (en_cnt - eb >= 2);
            end
            chk("abort_wait_run2", met, 1'b1);
            arst_n = 1'b0;
            #1;
            check_quiet("abort_reset");
            chk("abort_pending_writes", exp_i.size() + exp_d.size(), 0);
            exp_o.delete();
            repeat (2) @(negedge clk);
            #1;
            arst_n = 1'b1;
            @(negedge clk);
            #1;
            chk("abort_idle_after_release", {busy, done, cpu_rst_n, cpu_enable}, 4'b0000);
            lat = 0;
            return;
        end
        met = 1'b0;
        lat = 0;
        for (t = 0; t < LIMIT && !met; t++) begin
            @(negedge clk);
            #1;
            met = done;
            lat = t + 1;
        end
        chk("session_done", met, 1'b1);
        chk("done_flags", {done, busy, cpu_rst_n, cpu_enable}, 4'b1010);
        chk("enable_cycles", en_cnt - eb, rc);
        chk("enable_rises", en_rises - rb, (rc != 0) ? 1 : 0);
        chk("leftover_expectations", exp_i.size() + exp_d.size() + exp_o.size(), 0);
        chk("stream_drained", in_q.size(), 0);
        chk("ren_ext_never", ren_seen, 1'b0);
    endtask

    initial begin
        int lat;
        arst_n     = 1'b0;
        start      = 1'b0;
        imem_len   = '0;
        dmem_len   = '0;
        run_cycles = '0;
        dump_len   = '0;
        repeat (3) @(negedge clk);
        check_quiet("in_reset");
        #1;
        arst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_quiet("idle_after_reset");

        // Zero-length session goes straight to DONE.
        run_session(0, 0, 0, 0, 1'b0, 1'b0, lat);
        chk("zero_len_latency_le2", lat <= 2, 1'b1);

        // Directed session with the reference stream.
        fixed_q = '{64'h13, 64'h93, 64'h113, 64'hAA, 64'hBB};
        run_session(3, 2, 5, 2, 1'b0, 1'b0, lat);

        // Gapped input and 4-cycle output stalls.
        in_mode = 1;
        or_mode = 2;
        run_session(7, 5, 3, 6, 1'b0, 1'b0, lat);

        // Length clamping.
        in_mode = 0;
        or_mode = 1;
        run_session(200, 1, 1, 1, 1'b0, 1'b0, lat);
        run_session(0, 300, 0, 300, 1'b0, 1'b0, lat);

        // start while running is ignored.
        run_session(2, 2, 12, 2, 1'b1, 1'b0, lat);

        // Reset in RUN, then a fresh session from counter zero.
        run_session(3, 3, 10, 3, 1'b0, 1'b1, lat);
        run_session(4, 3, 2, 3, 1'b0, 1'b0, lat);

        for (int r = 0; r < 10; r++) begin
            in_mode = $urandom_range(0, 2);
            or_mode = $urandom_range(0, 2);
            run_session($urandom_range(0, 8), $urandom_range(0, 8), $urandom_range(0, 10),
                        $urandom_range(0, 10), 1'b0, 1'b0, lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
